// File: rtl/triad_encode_pkg.sv
// Shared definitions for the triad link; both encode and decode ends use this bit order.
package triad_encode_pkg;

   localparam int unsigned TRIAD_LEN = 3;
   localparam int unsigned HS_W      = 2;
   localparam int unsigned DT_W      = 4;

   // Triad serial slots: start bit, strip bit, half-strip bit, then optional dead time.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      B0   = 3'd1,
      B1   = 3'd2,
      B2   = 3'd3,
      DEAD = 3'd4
   } state_t;

   // Serial value driven in a given slot for a latched half-strip index.
   function automatic logic triad_bit(input state_t st, input logic [HS_W-1:0] hs_v);
      case (st)
         B0:      return 1'b1;
         B1:      return hs_v[1];
         B2:      return hs_v[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/triad_encode_if.sv
// Request handshake into the triad encoder: hit request, half-strip index and buffer-ready.
interface triad_encode_if;
   import triad_encode_pkg::*;

   logic            req;
   logic [HS_W-1:0] hs;
   logic            ready;

   modport master (output req, output hs, input ready);
   modport slave  (input req, input hs, output ready);
endinterface

// File: rtl/triad_encode.sv
// Distrip triad serializer with one-entry pending buffer, programmable dead time
// and a saturating dropped-request counter.
module triad_encode
   import triad_encode_pkg::*;
#(
   parameter int unsigned DROP_CNT_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   triad_encode_if.slave         link,
   input  logic [DT_W-1:0]       dead_time,
   input  logic                  drop_cnt_rst,
   output logic                  triad,
   output logic                  busy,
   output logic                  sent,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   state_t          state, next_state;
   logic [HS_W-1:0] hs_l, hs_l_n;
   logic            buf_valid, buf_valid_n;
   logic [HS_W-1:0] buf_hs, buf_hs_n;
   logic [DT_W-1:0] dead_cnt, dead_cnt_n;
   logic            drop_inc;
   logic            start;
   logic            pending;
   logic            triad_n, sent_n;
   logic            ready_q;

   assign link.ready = ready_q;

   // Next-state, buffer bookkeeping and next-cycle output values.
   always_comb begin
      next_state  = state;
      hs_l_n      = hs_l;
      buf_valid_n = buf_valid;
      buf_hs_n    = buf_hs;
      dead_cnt_n  = dead_cnt;
      drop_inc    = 1'b0;
      start       = 1'b0;
      pending     = buf_valid | link.req;
      triad_n     = 1'b0;
      sent_n      = 1'b0;

      case (state)
         IDLE: begin
            if (pending) start = 1'b1;
         end
         B0: next_state = B1;
         B1: next_state = B2;
         B2: begin
            if (dead_time != '0) begin
               next_state = DEAD;
               dead_cnt_n = dead_time;
            end else if (pending) begin
               start = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         DEAD: begin
            if (dead_cnt == DT_W'(1)) begin
               if (pending) start = 1'b1;
               else         next_state = IDLE;
            end else begin
               dead_cnt_n = dead_cnt - DT_W'(1);
            end
         end
         default: next_state = IDLE;
      endcase

      // Buffered entry is served first; a simultaneous new request refills the buffer.
      if (start) begin
         next_state = B0;
         if (buf_valid) begin
            hs_l_n      = buf_hs;
            buf_valid_n = link.req;
            if (link.req) buf_hs_n = link.hs;
         end else begin
            hs_l_n = link.hs;
         end
      end else if (link.req) begin
         if (!buf_valid) begin
            buf_valid_n = 1'b1;
            buf_hs_n    = link.hs;
         end else begin
            drop_inc = 1'b1;
         end
      end

      triad_n = triad_bit(next_state, hs_l_n);
      sent_n  = (next_state == B2);
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Latched index, pending buffer and dead-time counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hs_l      <= '0;
         buf_valid <= 1'b0;
         buf_hs    <= '0;
         dead_cnt  <= '0;
      end else begin
         hs_l      <= hs_l_n;
         buf_valid <= buf_valid_n;
         buf_hs    <= buf_hs_n;
         dead_cnt  <= dead_cnt_n;
      end
   end

   // Registered outputs, aligned with the state they describe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         triad   <= 1'b0;
         sent    <= 1'b0;
         busy    <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         triad   <= triad_n;
         sent    <= sent_n;
         busy    <= (next_state != IDLE);
         ready_q <= !buf_valid_n;
      end
   end

   // Saturating drop counter; clear wins over a same-cycle increment.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (drop_cnt_rst) begin
         drop_cnt <= '0;
      end else if (drop_inc && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_triad_encode.sv
// Randomized and directed bench for triad_encode against a slot-queue reference model.
module tb_triad_encode;
   import triad_encode_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  dead_time;
   logic        drop_cnt_rst;
   logic        triad, busy, sent;
   logic [15:0] drop_cnt;

   triad_encode_if link();

   triad_encode #(.DROP_CNT_W(16)) dut (
      .clock        (clk),
      .reset        (reset),
      .link         (link.slave),
      .dead_time    (dead_time),
      .drop_cnt_rst (drop_cnt_rst),
      .triad        (triad),
      .busy         (busy),
      .sent         (sent),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic hist_triad [0:63];
   logic hist_sent  [0:63];
   logic hist_busy  [0:63];
   logic hist_ready [0:63];

   // Reference model: queue of upcoming line slots {sent, triad}, one pending entry, drop count.
   logic [1:0] slots[$];
   logic       m_buf_v;
   logic [1:0] m_buf_hs;
   int         m_drop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
      end
   endtask

   task automatic model_reset();
      slots.delete();
      m_buf_v  = 1'b0;
      m_buf_hs = 2'd0;
      m_drop   = 0;
   endtask

   task automatic model_step(input logic r, input logic [1:0] h, input logic [3:0] dt, input logic dcr);
      logic [1:0] s;
      logic [1:0] jh;
      if (slots.size() > 0) begin
         s = slots.pop_front();
         if (s[1]) for (int k = 0; k < int'(dt); k++) slots.push_back(2'b00);
      end
      if (slots.size() == 0 && (m_buf_v || r)) begin
         if (m_buf_v) begin
            jh = m_buf_hs;
            if (r) m_buf_hs = h;
            else   m_buf_v  = 1'b0;
         end else begin
            jh = h;
         end
         slots.push_back(2'b01);
         slots.push_back({1'b0, jh[1]});
         slots.push_back({1'b1, jh[0]});
      end else if (r) begin
         if (!m_buf_v) begin
            m_buf_v  = 1'b1;
            m_buf_hs = h;
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
      if (dcr) m_drop = 0;
   endtask

   function automatic logic m_triad();
      logic [1:0] s;
      if (slots.size() == 0) return 1'b0;
      s = slots[0];
      return s[0];
   endfunction

   function automatic logic m_sent();
      logic [1:0] s;
      if (slots.size() == 0) return 1'b0;
      s = slots[0];
      return s[1];
   endfunction

   // One clock cycle: drive, compare at negedge, advance model at posedge.
   task automatic tick(input logic r, input logic [1:0] h, input logic [3:0] dt, input logic dcr);
      link.req     = r;
      link.hs      = r ? h : 2'($urandom);
      dead_time    = dt;
      drop_cnt_rst = dcr;
      @(negedge clk);
      if (cyc < 64) begin
         hist_triad[cyc] = triad;
         hist_sent[cyc]  = sent;
         hist_busy[cyc]  = busy;
         hist_ready[cyc] = link.ready;
      end
      chk("triad", 32'(triad), 32'(m_triad()));
      chk("sent",  32'(sent),  32'(m_sent()));
      chk("busy",  32'(busy),  32'(slots.size() != 0));
      chk("ready", 32'(link.ready), 32'(!m_buf_v));
      chk("drop",  32'(drop_cnt), 32'(m_drop));
      @(posedge clk);
      model_step(r, h, dt, dcr);
      #1;
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_triad"}, 32'(triad), 32'd0);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_ready"}, 32'(link.ready), 32'd1);
      chk({tag, "_sent"},  32'(sent),  32'd0);
      chk({tag, "_drop"},  32'(drop_cnt), 32'd0);
   endtask

   logic [3:0] dt_r;
   logic [2:0] bits3;
   logic [3:0] onehot;

   initial begin
      reset        = 1'b1;
      link.req     = 1'b0;
      link.hs      = 2'd0;
      dead_time    = 4'd0;
      drop_cnt_rst = 1'b0;
      model_reset();
      #1;
      chk_reset_outputs("rst");
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed: single triad with dead_time=2.
      cyc = 0;
      for (int i = 0; i < 20; i++) tick(i == 10, 2'd2, 4'd2, i == 0);
      chk("t1_triad", 32'({hist_triad[11], hist_triad[12], hist_triad[13], hist_triad[14], hist_triad[15]}), 32'b11000);
      chk("t1_sent",  32'({hist_sent[12], hist_sent[13], hist_sent[14]}), 32'b010);
      chk("t1_busy",  32'({hist_busy[10], hist_busy[11], hist_busy[15], hist_busy[16]}), 32'b0110);

      // Directed: back-to-back triads with dead_time=0.
      cyc = 0;
      for (int i = 0; i < 20; i++)
         tick(i == 10 || i == 11, (i == 10) ? 2'd3 : 2'd1, 4'd0, i == 0);
      chk("t2_triad", 32'({hist_triad[11], hist_triad[12], hist_triad[13],
                          hist_triad[14], hist_triad[15], hist_triad[16], hist_triad[17]}), 32'b1111010);
      chk("t2_ready", 32'({hist_ready[11], hist_ready[12], hist_ready[15]}), 32'b101);
      chk("t2_drop",  32'(drop_cnt), 32'd0);

      // Directed: buffer full drop, then request during second triad accepted.
      cyc = 0;
      for (int i = 0; i < 40; i++)
         tick(i == 10 || i == 11 || i == 12 || i == 20, (i == 20) ? 2'd3 : 2'(i - 10), 4'd5, i == 0);
      chk("t3_first",  32'({hist_triad[11], hist_triad[12], hist_triad[13]}), 32'b100);
      chk("t3_second", 32'({hist_triad[19], hist_triad[20], hist_triad[21]}), 32'b101);
      chk("t3_third",  32'({hist_triad[27], hist_triad[28], hist_triad[29]}), 32'b111);
      chk("t3_drop",   32'(drop_cnt), 32'd1);

      // Directed: asynchronous reset in the middle of a triad.
      cyc = 0;
      for (int i = 0; i < 12; i++) tick(i == 10, 2'd3, 4'd2, 1'b0);
      chk("t4_pre", 32'(triad), 32'd1);
      link.req = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk_reset_outputs("t4");
      model_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      cyc = 0;
      for (int i = 0; i < 12; i++) tick(i == 3, 2'd1, 4'd1, 1'b0);
      chk("t4_post", 32'({hist_triad[3], hist_triad[4], hist_triad[5], hist_triad[6], hist_triad[7]}), 32'b01010);

      // Directed: drop counter saturation and clear-over-increment.
      cyc = 0;
      for (int i = 0; i < 70000; i++) tick(1'b1, 2'($urandom), 4'd15, i == 0);
      chk("t5_sat", 32'(drop_cnt), 32'h0000FFFF);
      tick(1'b1, 2'd0, 4'd15, 1'b1);
      chk("t5_clr", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 40; i++) tick(1'b0, 2'd0, 4'd0, 1'b0);

      // Loopback decode of each half-strip value.
      for (int h = 0; h < 4; h++) begin
         cyc = 0;
         for (int i = 0; i < 10; i++) tick(i == 1, 2'(h), 4'd0, 1'b0);
         for (int b = 0; b < int'(TRIAD_LEN); b++) bits3[2 - b] = hist_triad[2 + b];
         onehot = bits3[2] ? 4'(4'd1 << bits3[1:0]) : 4'd0;
         chk("loop_hs", 32'(onehot), 32'(4'd1 << h));
         chk("loop_skip", 32'(hist_triad[5]), 32'd0);
      end

      // Randomized traffic against the model.
      dt_r = 4'd1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 5) dt_r = 4'($urandom_range(0, 3));
         tick($urandom_range(0, 99) < 45, 2'($urandom), dt_r, $urandom_range(0, 199) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
